// File: rtl/fm_pkg.sv
// Shared FM types: message width and the signed message word used by the
// interpolator and the FM modulator's message port.
package fm_pkg;

  localparam int MSG_W = 8;

  typedef logic signed [MSG_W-1:0] msg_t;

endpackage

// File: rtl/fm_msg_fifo.sv
// Small synchronous FIFO for incoming message samples; no push-to-pop bypass,
// so a pop on an empty FIFO never sees a same-cycle push.
module fm_msg_fifo
  import fm_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  msg_t                     push_data,
  input  logic                     pop,
  output msg_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  msg_t                       mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic                       do_push;
  logic                       do_pop;

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // storage is not reset; only pointers and level define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fm_message_interp.sv
// Message feeder for the FM modulator: buffers low-rate samples and spreads each
// over 2**RATE_LOG2 clocks. Define FM_MSG_INTERP_EN for linear interpolation;
// otherwise zero-order hold.
module fm_message_interp
  import fm_pkg::*;
#(
  parameter int RATE_LOG2       = 8,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  msg_t                     s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output msg_t                     message,
  output logic                     underrun,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

  localparam logic [RATE_LOG2-1:0] PHASE_ONE = RATE_LOG2'(1);

  logic                 alive;
  logic                 full;
  logic                 empty;
  msg_t                 head;
  logic [RATE_LOG2-1:0] phase;
  msg_t                 cur;
  logic                 boundary;
  logic                 pop;
  msg_t                 msg_next;

  // s_ready stays low through reset and rises on the first cycle after release
  always_ff @(posedge clk) begin
    if (!reset) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  assign s_ready  = alive & ~full;
  assign boundary = enable & (phase == '1);
  assign pop      = boundary & ~empty;

  fm_msg_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (s_valid & s_ready),
    .push_data(s_data),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase    <= '0;
      cur      <= '0;
      message  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= boundary & empty;
      if (enable) begin
        phase   <= phase + PHASE_ONE;
        message <= msg_next;
      end
      if (pop) begin
        cur <= head;
      end
    end
  end

`ifdef FM_MSG_INTERP_EN
  localparam int PW = MSG_W + 1 + RATE_LOG2;

  msg_t                  prev;
  logic signed [MSG_W:0] diff;
  logic signed [PW-1:0]  prod;

  // on an empty boundary prev catches up with cur, so the output goes flat
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= '0;
    end else if (boundary) begin
      prev <= cur;
    end
  end

  // result lies between prev and cur, so modulo-256 arithmetic is exact
  always_comb begin
    diff     = {cur[MSG_W-1], cur} - {prev[MSG_W-1], prev};
    prod     = PW'(diff) * $signed(PW'({1'b0, phase}));
    msg_next = prev + msg_t'(prod >>> RATE_LOG2);
  end
`else
  assign msg_next = cur;
`endif

endmodule

// File: tb/tb_fm_message_interp.sv
// Scoreboard bench for fm_message_interp (RATE_LOG2=2, FIFO_DEPTH_LOG2=2); the
// reference model follows FM_MSG_INTERP_EN the same way the design does.
module tb_fm_message_interp;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              s_valid = 1'b0;
  logic signed [7:0] s_data = 8'sd0;
  logic              s_ready;
  logic signed [7:0] message;
  logic              underrun;
  logic [2:0]        fifo_level;

  always #5 clk = ~clk;

  fm_message_interp #(
    .RATE_LOG2      (2),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .message   (message),
    .underrun  (underrun),
    .fifo_level(fifo_level)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int msg;
    int und;
    int lvl;
    int rdy;
  } exp_t;

  exp_t exp_q[$];
  int   m_q[$];
  int   m_phase, m_prev, m_cur, m_msg, m_und;
  bit   m_alive;

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // reference model advanced on every rising edge; pushes the expected outputs
  task automatic model_step();
    exp_t e;
    int   d;
    bit   push, bnd, was_empty;
    if (!reset) begin
      m_q.delete();
      m_alive = 1'b0;
      m_phase = 0; m_prev = 0; m_cur = 0; m_msg = 0; m_und = 0;
    end else begin
      push      = s_valid && m_alive && (m_q.size() < 4);
      was_empty = (m_q.size() == 0);
      bnd       = enable && (m_phase == 3);
      if (enable) begin
`ifdef FM_MSG_INTERP_EN
        d     = (m_cur - m_prev) * m_phase;
        m_msg = m_prev + (d >>> 2);
`else
        m_msg = m_cur;
`endif
      end
      m_und = (bnd && was_empty) ? 1 : 0;
      if (bnd) begin
        m_prev = m_cur;
        if (!was_empty) m_cur = m_q.pop_front();
      end
      if (enable) m_phase = (m_phase + 1) % 4;
      if (push) m_q.push_back(int'(s_data));
      m_alive = 1'b1;
    end
    e.msg = m_msg;
    e.und = m_und;
    e.lvl = m_q.size();
    e.rdy = (m_alive && (m_q.size() < 4)) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin : sb_compare
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_message", int'(message), e.msg);
      check("sb_underrun", int'(underrun), e.und);
      check("sb_level", int'(fifo_level), e.lvl);
      check("sb_ready", int'(s_ready), e.rdy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  task automatic send(input int v);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'(v);
    for (int i = 0; i < 30 && !done; i++) begin
      done = s_ready;
      step();
    end
    s_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  int ramp_exp[8];
  int ext_trig;
  int ext_exp[4];
  int acc;
  int hold;
  bit found;

  initial begin
`ifdef FM_MSG_INTERP_EN
    ramp_exp = '{16, 32, 48, 64, 48, 32, 16, 0};
    ext_trig = -65;
    ext_exp  = '{-1, 63, 127, 127};
`else
    ramp_exp = '{64, 64, 64, 64, 0, 0, 0, 0};
    ext_trig = -128;
    ext_exp  = '{-128, -128, -128, 127};
`endif

    // reset held 3 clocks with s_valid asserted
    reset = 1'b0; s_valid = 1'b1; s_data = 8'sd5; enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", int'(s_ready), 0);
      check("rst_level", int'(fifo_level), 0);
      check("rst_msg", int'(message), 0);
      check("rst_und", int'(underrun), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", int'(s_ready), 1);
    check("rel_level", int'(fifo_level), 0);
    s_valid = 1'b0;

    // ramp 64 -> 0
    do_reset(2);
    send(64);
    send(0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (message != 8'sd0) found = 1'b1;
    end
    check("ramp_seen", int'(found), 1);
    if (found) begin
      check("ramp_0", int'(message), ramp_exp[0]);
      for (int k = 1; k < 8; k++) begin
        @(negedge clk);
        check("ramp_k", int'(message), ramp_exp[k]);
      end
    end

    // extremes -128 -> 127
    send(-128);
    send(127);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (int'(message) == ext_trig) found = 1'b1;
    end
    check("ext_seen", int'(found), 1);
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("ext_k", int'(message), ext_exp[k]);
      end
    end
    repeat (8) step();

    // backpressure with enable low
    enable = 1'b0;
    s_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      s_data = 8'(10 * k + 1);
      if (s_ready) acc++;
      step();
    end
    check("bp_accepted", acc, 4);
    check("bp_ready", int'(s_ready), 0);
    check("bp_level", int'(fifo_level), 4);
    s_valid = 1'b0;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fifo_level != 3'd4) found = 1'b1;
    end
    check("bp_pop_seen", int'(found), 1);
    check("bp_ready_after_pop", int'(s_ready), 1);
    repeat (20) step();

    // underrun after a single sample, then push coinciding with a boundary
    do_reset(2);
    send(40);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (underrun) found = 1'b1;
    end
    check("und_seen", int'(found), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("und_hold_msg", int'(message), 40);
      if (k == 0) check("und_single_pulse", int'(underrun), 0);
    end
    repeat (3) @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'sd40;
    @(negedge clk);
    s_valid = 1'b0;
    check("und_same_cycle", int'(underrun), 1);
    check("und_same_level", int'(fifo_level), 1);
    repeat (12) step();

    // enable freeze mid-ramp
    do_reset(2);
    send(64);
    send(0);
    repeat (5) step();
    enable = 1'b0;
    hold = m_msg;
    repeat (5) begin
      @(negedge clk);
      check("frz_msg", int'(message), hold);
      check("frz_und", int'(underrun), 0);
    end
    enable = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
